hazard_sched: RTL and testbench

HAZARD_SCHED -- requirements
Module: hazard_sched

---
 rtl/hazard_sched.sv | 151 +++++++++++++++
 tb/tb_hazard_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - pipeline hazard unit with multiply/divide busy tracker
// Optional feature macro: HAZARD_SCHED_PERF_EN adds a 32-bit stall cycle counter (stall_cnt).
module hazard_sched #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       branch_d,
  input  logic       j_src_d,
  input  logic       hilo_use_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] rf_wae,
  input  logic       we_rege,
  input  logic [1:0] dm2rege,
  input  logic       mdu_start,
  input  logic       mdu_div,
  input  logic [4:0] rf_wam,
  input  logic       we_regm,
  input  logic [1:0] dm2regm,
  input  logic [4:0] rf_waw,
  input  logic       we_regw,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic       forward_ad,
  output logic       forward_bd,
  output logic [1:0] forward_ae,
  output logic [1:0] forward_be,
  output logic       mdu_busy,
  output logic       mdu_done
`ifdef HAZARD_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter preload is two less than the total: the accept cycle and the DONE cycle are not counted down.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 2);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       load_use_stall;
  logic       branch_stall;
  logic       hilo_stall;
  logic       stall;

  // Execute-stage operand forwarding: Memory result has priority over Writeback.
  always_comb begin
    forward_ae = 2'b00;
    forward_be = 2'b00;
    if (rs_e != 5'd0 && rs_e == rf_wam && we_regm) forward_ae = 2'b10;
    else if (rs_e != 5'd0 && rs_e == rf_waw && we_regw) forward_ae = 2'b01;
    if (rt_e != 5'd0 && rt_e == rf_wam && we_regm) forward_be = 2'b10;
    else if (rt_e != 5'd0 && rt_e == rf_waw && we_regw) forward_be = 2'b01;
  end

  // Decode comparator forwarding and the three stall sources.
  always_comb begin
    forward_ad     = (rs_d != 5'd0) && (rs_d == rf_wam) && we_regm;
    forward_bd     = (rt_d != 5'd0) && (rt_d == rf_wam) && we_regm;
    load_use_stall = (dm2rege == 2'b01) && (rf_wae != 5'd0) &&
                     ((rf_wae == rs_d) || (rf_wae == rt_d));
    branch_stall   = 1'b0;
    // A branch compares both sources; a jr only reads rs.
    if (branch_d && ((we_rege && rf_wae != 5'd0 && (rf_wae == rs_d || rf_wae == rt_d)) ||
                     (dm2regm == 2'b01 && rf_wam != 5'd0 && (rf_wam == rs_d || rf_wam == rt_d))))
      branch_stall = 1'b1;
    if (j_src_d && ((we_rege && rf_wae != 5'd0 && rf_wae == rs_d) ||
                    (dm2regm == 2'b01 && rf_wam != 5'd0 && rf_wam == rs_d)))
      branch_stall = 1'b1;
    hilo_stall = hilo_use_d && ((state_q == BUSY) || mdu_start);
    stall      = load_use_stall || branch_stall || hilo_stall;
    stall_f    = stall;
    stall_d    = stall;
    flush_e    = stall;
  end

  // MDU next-state: a start is only taken from IDLE or DONE, so BUSY ignores it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mdu_start) begin
          state_d = BUSY;
          cnt_d   = mdu_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == 6'd0) state_d = DONE;
        else cnt_d = cnt_q - 6'd1;
      end
      DONE: begin
        if (mdu_start) begin
          state_d = BUSY;
          cnt_d   = mdu_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // MDU state and countdown registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mdu_busy = (state_q == BUSY);
  assign mdu_done = (state_q == DONE);

`ifdef HAZARD_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall cycle count; wraps naturally at 32 bits.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 32'd0;
    else stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - self-checking bench for hazard_sched with a cycle-level reference model
module tb_hazard_sched;
  localparam int MC = 4;
  localparam int DC = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, rf_wae, rf_wam, rf_waw;
  logic       branch_d, j_src_d, hilo_use_d, we_rege, mdu_start, mdu_div, we_regm, we_regw;
  logic [1:0] dm2rege, dm2regm;
  logic       stall_f, stall_d, flush_e, forward_ad, forward_bd, mdu_busy, mdu_done;
  logic [1:0] forward_ae, forward_be;
`ifdef HAZARD_SCHED_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // reference MDU model: cycles elapsed since the accepting cycle
  bit m_act;
  int m_t;
  int m_n;

  always #5 clk = ~clk;

  hazard_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .j_src_d(j_src_d), .hilo_use_d(hilo_use_d),
    .rs_e(rs_e), .rt_e(rt_e), .rf_wae(rf_wae), .we_rege(we_rege), .dm2rege(dm2rege),
    .mdu_start(mdu_start), .mdu_div(mdu_div),
    .rf_wam(rf_wam), .we_regm(we_regm), .dm2regm(dm2regm),
    .rf_waw(rf_waw), .we_regw(we_regw),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef HAZARD_SCHED_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic clear_inputs();
    {rs_d, rt_d, rs_e, rt_e, rf_wae, rf_wam, rf_waw} = '0;
    {branch_d, j_src_d, hilo_use_d, we_rege, mdu_start, mdu_div, we_regm, we_regw} = '0;
    dm2rege = 2'b00;
    dm2regm = 2'b00;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref_fwd_e(logic [4:0] r);
    if (r != 0 && r == rf_wam && we_regm) return 2'b10;
    if (r != 0 && r == rf_waw && we_regw) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_stall();
    logic lu, br, jr, hl;
    lu = dm2rege == 2'b01 && rf_wae != 0 && (rf_wae == rs_d || rf_wae == rt_d);
    br = branch_d && ((we_rege && rf_wae != 0 && (rf_wae == rs_d || rf_wae == rt_d)) ||
                      (dm2regm == 2'b01 && rf_wam != 0 && (rf_wam == rs_d || rf_wam == rt_d)));
    jr = j_src_d && ((we_rege && rf_wae != 0 && rf_wae == rs_d) ||
                     (dm2regm == 2'b01 && rf_wam != 0 && rf_wam == rs_d));
    hl = hilo_use_d && ((m_act && m_t < m_n) || mdu_start);
    return lu || br || jr || hl;
  endfunction

  task automatic model_edge();
    if (!m_act || m_t == m_n) begin
      if (mdu_start) begin
        m_act = 1'b1;
        m_t = 1;
        m_n = mdu_div ? DC : MC;
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    m_act = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    n_cmp++;
    if ({stall_f, stall_d, flush_e, forward_ad, forward_bd, forward_ae, forward_be, mdu_busy, mdu_done} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 0", {stall_f, stall_d, flush_e, forward_ad, forward_bd, forward_ae, forward_be, mdu_busy, mdu_done});
    end
`ifdef HAZARD_SCHED_PERF_EN
    n_cmp++;
    if (stall_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt);
    end
`endif
    do_reset();
  endtask

  task automatic test_forward();
    logic [1:0] exp_tbl [3] = '{2'b10, 2'b01, 2'b00};
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      rs_e = (i == 2) ? 5'd0 : 5'd5;
      rf_wam = 5'd5; we_regm = (i == 0); rf_waw = 5'd5; we_regw = 1'b1;
      #2;
      n_cmp++;
      if (forward_ae !== exp_tbl[i]) begin
        n_bad++;
        $display("FAIL forward_ae_case%0d: got %b required %b", i, forward_ae, exp_tbl[i]);
      end
    end
    rt_e = 5'd9; rf_wam = 5'd9; we_regm = 1'b1; rs_d = 5'd9; rt_d = 5'd0;
    #2;
    n_cmp++;
    if ({forward_be, forward_ad, forward_bd} !== 4'b1010) begin
      n_bad++;
      $display("FAIL forward_be_ad_bd: got %b required 1010", {forward_be, forward_ad, forward_bd});
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    dm2rege = 2'b01; rf_wae = 5'd8; rt_d = 5'd8;
    #2;
    n_cmp++;
    if ({stall_f, stall_d, flush_e} !== 3'b111) begin
      n_bad++;
      $display("FAIL load_use_stall: got %b required 111", {stall_f, stall_d, flush_e});
    end
    rf_wae = 5'd0; rt_d = 5'd0;
    #2;
    n_cmp++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      n_bad++;
      $display("FAIL load_use_r0: got %b required 000", {stall_f, stall_d, flush_e});
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    next_cycle();
    branch_d = 1'b1; rs_d = 5'd3; we_rege = 1'b1; rf_wae = 5'd3;
    @(negedge clk);
    n_cmp++;
    if (stall_d !== 1'b1) begin
      n_bad++;
      $display("FAIL branch_ex_stall: got %b required 1", stall_d);
    end
    next_cycle();
    we_rege = 1'b0; rf_wae = 5'd0; rf_wam = 5'd3; we_regm = 1'b1; dm2regm = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({stall_d, forward_ad} !== 2'b01) begin
      n_bad++;
      $display("FAIL branch_mem_fwd: got stall=%b fwd_ad=%b required stall=0 fwd_ad=1", stall_d, forward_ad);
    end
    dm2regm = 2'b01;
    branch_d = 1'b0; j_src_d = 1'b1; rt_d = 5'd0;
    #1;
    n_cmp++;
    if (stall_d !== 1'b1) begin
      n_bad++;
      $display("FAIL jr_mem_load_stall: got %b required 1", stall_d);
    end
    rs_d = 5'd4; rt_d = 5'd3;
    #1;
    n_cmp++;
    if (stall_d !== 1'b0) begin
      n_bad++;
      $display("FAIL jr_ignores_rt: got %b required 0", stall_d);
    end
    clear_inputs();
  endtask

  task automatic test_mult();
    clear_inputs();
    next_cycle();
    mdu_start = 1'b1; mdu_div = 1'b0;
    next_cycle();
    mdu_start = 1'b0; hilo_use_d = 1'b1;
    for (int c = 1; c <= MC + 1; c++) begin
      logic [2:0] want;
      want = (c < MC) ? 3'b101 : (c == MC) ? 3'b010 : 3'b000;
      @(negedge clk);
      n_cmp++;
      if ({mdu_busy, mdu_done, stall_d} !== want) begin
        n_bad++;
        $display("FAIL mult_cycle%0d: got busy/done/stall=%b required %b", c, {mdu_busy, mdu_done, stall_d}, want);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_div_reset();
    int cycles;
    clear_inputs();
    next_cycle();
    mdu_start = 1'b1; mdu_div = 1'b1;
    next_cycle();
    mdu_start = 1'b0; mdu_div = 1'b0;
    repeat (9) next_cycle();
    #1;
    n_cmp++;
    if (mdu_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL div_busy_before_rst: got %b required 1", mdu_busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mdu_busy, mdu_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL div_async_rst: got busy/done=%b required 00", {mdu_busy, mdu_done});
    end
    next_cycle();
    rst = 1'b0; mdu_start = 1'b1;
    next_cycle();
    mdu_start = 1'b0;
    cycles = 1;
    while (mdu_done !== 1'b1 && cycles < 20) begin
      next_cycle();
      cycles++;
    end
    n_cmp++;
    if (cycles != MC) begin
      n_bad++;
      $display("FAIL mult_after_rst_latency: got %0d required %0d", cycles, MC);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    logic [11:0] got, want;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      rf_wae = 5'($urandom_range(0, 3)); rf_wam = 5'($urandom_range(0, 3)); rf_waw = 5'($urandom_range(0, 3));
      branch_d = 1'($urandom_range(0, 1)); j_src_d = ($urandom_range(0, 3) == 0);
      hilo_use_d = 1'($urandom_range(0, 1)); we_rege = 1'($urandom_range(0, 1));
      dm2rege = 2'($urandom_range(0, 3)); dm2regm = 2'($urandom_range(0, 3));
      we_regm = 1'($urandom_range(0, 1)); we_regw = 1'($urandom_range(0, 1));
      mdu_start = ($urandom_range(0, 7) == 0); mdu_div = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = {stall_f, stall_d, flush_e, forward_ad, forward_bd, forward_ae, forward_be, mdu_busy, mdu_done, 1'b0};
      want = {{3{ref_stall()}},
              (rs_d != 0 && rs_d == rf_wam && we_regm), (rt_d != 0 && rt_d == rf_wam && we_regm),
              ref_fwd_e(rs_e), ref_fwd_e(rt_e),
              (m_act && m_t < m_n), (m_act && m_t == m_n), 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got %b required %b", i, got, want);
      end
      @(posedge clk);
      model_edge();
      #1;
    end
    clear_inputs();
  endtask

`ifdef HAZARD_SCHED_PERF_EN
  task automatic test_perf();
    do_reset();
    dm2rege = 2'b01; rf_wae = 5'd8; rt_d = 5'd8;
    repeat (7) next_cycle();
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== 32'd7) begin
      n_bad++;
      $display("FAIL perf_stall_cnt: got %0d required 7", stall_cnt);
    end
  endtask
`endif

  initial begin
    m_act = 1'b0; m_t = 0; m_n = MC;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mult();
    test_div_reset();
    test_random();
`ifdef HAZARD_SCHED_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
